conv_window_sequencer: RTL

Control FSM that sequences the single shared processing element through a windowed convolution: it walks filter taps and output windows, drives the PE enable and clear, and strobes the output memory capture. It replaces the free-running, self-stopping counter in the 1×1 systolic top with a start/busy/done handshake, stall support and re-runnable jobs. The sequencer sits between the host control logic and the PE datapath and its operand muxes; `tap_idx` and `win_idx` drive the input and filter mux selects directly.

---
 rtl/conv_window_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
// Control FSM that walks filter taps and output windows for a single shared PE,
// with a start/busy/done handshake, tap-level stalls and re-runnable jobs.
module conv_window_sequencer #(
  parameter int TAPS    = 9,
  parameter int WINDOWS = 4
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic       pe_en,
  output logic       pe_clr,
  output logic [3:0] tap_idx,
  output logic [1:0] win_idx,
  output logic       cap_en,
  output logic [1:0] cap_idx
);

  typedef enum logic [1:0] {IDLE, RUN, CAP, DONE} state_t;

  localparam logic [3:0] TAP_LAST = 4'(TAPS - 1);
  localparam logic [1:0] WIN_LAST = 2'(WINDOWS - 1);

  state_t     state_q, state_d;
  logic [3:0] tap_q;
  logic [1:0] win_q;
  logic       tap_last, win_last;

  assign tap_last = (tap_q == TAP_LAST);
  assign win_last = (win_q == WIN_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of process ordering.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!hold && tap_last) state_d = CAP;
      CAP:     state_d = win_last ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The tap counter parks at TAPS-1 through CAP and both counters are already
  // zero by the DONE cycle, so the mux selects never see an out-of-range value.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tap_q <= '0;
      win_q <= '0;
    end else begin
      unique case (state_q)
        RUN: if (!hold && !tap_last) tap_q <= tap_q + 4'd1;
        CAP: begin
          tap_q <= '0;
          win_q <= win_last ? 2'd0 : win_q + 2'd1;
        end
        default: begin
          tap_q <= '0;
          win_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    pe_en  = 1'b0;
    pe_clr = 1'b0;
    cap_en = 1'b0;
    unique case (state_q)
      RUN: begin
        busy  = 1'b1;
        pe_en = !hold;
      end
      CAP: begin
        busy   = 1'b1;
        pe_clr = 1'b1;
        cap_en = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign tap_idx = tap_q;
  assign win_idx = win_q;
  assign cap_idx = win_q;

endmodule
